// File: rtl/irq_seq_if.sv
// Sequencer-side signal bundle for irq_seq: event inputs from the core plus the
// entry-sequence bus controls it drives while busy.
interface irq_seq_if #(
    parameter int unsigned NUM_IRQ = 4
);
    logic               rdy;
    logic               sync;
    logic               I;
    logic               brk;
    logic               nmi;
    logic [NUM_IRQ-1:0] irq;
    logic [NUM_IRQ-1:0] irq_mask;
    logic [NUM_IRQ-1:0] edge_sel;

    logic               take;
    logic               busy;
    logic               WE;
    logic [1:0]         do_op;
    logic               sp_dec;
    logic [7:0]         vec;
    logic               B;
    logic [3:0]         src;
    logic               done;

    modport master (
        output rdy, sync, I, brk, nmi, irq, irq_mask, edge_sel,
        input  take, busy, WE, do_op, sp_dec, vec, B, src, done
    );

    modport slave (
        input  rdy, sync, I, brk, nmi, irq, irq_mask, edge_sel,
        output take, busy, WE, do_op, sp_dec, vec, B, src, done
    );
endinterface

// File: rtl/irq_seq.sv
// Interrupt arbiter and entry sequencer (reset, NMI, BRK, NUM_IRQ channels) for the 65C02 core.
// Define IRQ_EDGE_EN to enable per-channel edge mode (edge_sel) with latched irq_pend flops.
module irq_seq #(
    parameter int unsigned NUM_IRQ  = 4,
    parameter logic [7:0]  VEC_BASE = 8'hE0,
    parameter int unsigned NMI_SYNC = 2
) (
    input logic      clk,
    input logic      reset,
    irq_seq_if.slave bus
);

    if (NUM_IRQ < 1 || NUM_IRQ > 8) begin : g_bad_num_irq
        $error("irq_seq: NUM_IRQ must be 1..8");
    end
    if (32'(VEC_BASE) + 2 * NUM_IRQ > 32'hFA) begin : g_bad_vec_base
        $error("irq_seq: channel vectors overlap the NMI/RESET/BRK vectors");
    end
    if (NMI_SYNC > 3) begin : g_bad_sync
        $error("irq_seq: NMI_SYNC must be 0..3");
    end

    localparam int unsigned ReqW = NUM_IRQ + 1;

    typedef enum logic [3:0] {
        StIdle, StRst0, StRst1, StRst2, StPushH, StPushL, StPushP, StVecL, StVecH
    } state_e;

    state_e state_q, state_d;
    logic [3:0] src_q;
    logic [7:0] vec_q;
    logic       b_q;

    // nmi and irq share one synchroniser chain; bit 0 is nmi.
    logic [ReqW-1:0]    req_raw, req_s;
    logic               nmi_s;
    logic [NUM_IRQ-1:0] irq_s;

    assign req_raw = {bus.irq, bus.nmi};

    if (NMI_SYNC == 0) begin : g_nosync
        assign req_s = req_raw;
    end else begin : g_sync
        logic [NMI_SYNC-1:0][ReqW-1:0] sync_q;
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                sync_q <= '0;
            end else begin
                sync_q[0] <= req_raw;
                for (int k = 1; k < int'(NMI_SYNC); k++) sync_q[k] <= sync_q[k-1];
            end
        end
        assign req_s = sync_q[NMI_SYNC-1];
    end

    assign nmi_s = req_s[0];
    assign irq_s = req_s[ReqW-1:1];

    logic nmi_prev_q, nmi_pend_q, nmi_pend_d, nmi_rise;
    logic [NUM_IRQ-1:0] irq_req, irq_elig;

    logic       take;
    logic       win_any;
    logic [3:0] win_src;
    logic [7:0] win_vec;
    logic       win_b;

    assign nmi_rise = nmi_s & ~nmi_prev_q;

`ifdef IRQ_EDGE_EN
    logic [NUM_IRQ-1:0] irq_prev_q, irq_pend_q, irq_pend_d, irq_rise;

    assign irq_rise = irq_s & ~irq_prev_q;
    assign irq_req  = (bus.edge_sel & irq_pend_q) | (~bus.edge_sel & irq_s);

    // Clear the taken channel, but a fresh edge in the same cycle survives.
    always_comb begin
        irq_pend_d = '0;
        for (int i = 0; i < int'(NUM_IRQ); i++) begin
            irq_pend_d[i] = (irq_rise[i] & bus.edge_sel[i]) |
                            (irq_pend_q[i] & ~(take && win_src == 4'(i)));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_prev_q <= '0;
            irq_pend_q <= '0;
        end else begin
            irq_prev_q <= irq_s;
            irq_pend_q <= irq_pend_d;
        end
    end
`else
    logic [NUM_IRQ-1:0] unused_edge_sel;
    assign unused_edge_sel = bus.edge_sel;
    assign irq_req         = irq_s;
`endif

    assign irq_elig   = irq_req & bus.irq_mask & {NUM_IRQ{~bus.I}};
    assign nmi_pend_d = nmi_rise | (nmi_pend_q & ~(take && win_src == 4'd9));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            nmi_prev_q <= 1'b0;
            nmi_pend_q <= 1'b0;
        end else begin
            nmi_prev_q <= nmi_s;
            nmi_pend_q <= nmi_pend_d;
        end
    end

    // Priority NMI > lowest-index channel > BRK; the downward scan leaves the lowest index.
    always_comb begin
        win_any = 1'b0;
        win_src = 4'd0;
        win_vec = 8'hFE;
        win_b   = 1'b0;
        if (nmi_pend_q) begin
            win_any = 1'b1;
            win_src = 4'd9;
            win_vec = 8'hFA;
        end else begin
            for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
                if (irq_elig[i]) begin
                    win_any = 1'b1;
                    win_src = 4'(i);
                    win_vec = VEC_BASE + 8'(2 * i);
                end
            end
            if (!win_any && bus.brk) begin
                win_any = 1'b1;
                win_src = 4'd8;
                win_vec = 8'hFE;
                win_b   = 1'b1;
            end
        end
    end

    assign take = bus.sync & bus.rdy & (state_q == StIdle) & win_any;

    logic       we, sp_dec, done;
    logic [1:0] do_op;

    always_comb begin
        state_d = state_q;
        we      = 1'b0;
        do_op   = 2'b00;
        sp_dec  = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            StIdle:  if (take) state_d = StPushH;
            StRst0:  begin sp_dec = 1'b1; if (bus.rdy) state_d = StRst1; end
            StRst1:  begin sp_dec = 1'b1; if (bus.rdy) state_d = StRst2; end
            StRst2:  begin sp_dec = 1'b1; if (bus.rdy) state_d = StVecL; end
            StPushH: begin
                we = 1'b1; do_op = 2'b11; sp_dec = 1'b1;
                if (bus.rdy) state_d = StPushL;
            end
            StPushL: begin
                we = 1'b1; do_op = 2'b10; sp_dec = 1'b1;
                if (bus.rdy) state_d = StPushP;
            end
            StPushP: begin
                we = 1'b1; do_op = 2'b01; sp_dec = 1'b1;
                if (bus.rdy) state_d = StVecL;
            end
            StVecL:  if (bus.rdy) state_d = StVecH;
            StVecH:  begin done = bus.rdy; if (bus.rdy) state_d = StIdle; end
            default: state_d = StIdle;
        endcase
        // Asynchronous reset forces the bus controls quiet before the next edge.
        if (!reset) begin
            we     = 1'b0;
            do_op  = 2'b00;
            sp_dec = 1'b0;
            done   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StRst0;
            src_q   <= 4'd10;
            vec_q   <= 8'hFC;
            b_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (take) begin
                src_q <= win_src;
                vec_q <= win_vec;
                b_q   <= win_b;
            end
        end
    end

    assign bus.take   = take;
    assign bus.busy   = reset & (state_q != StIdle);
    assign bus.WE     = we;
    assign bus.do_op  = do_op;
    assign bus.sp_dec = sp_dec;
    assign bus.vec    = (state_q == StVecH) ? vec_q + 8'd1 : vec_q;
    assign bus.B      = b_q;
    assign bus.src    = src_q;
    assign bus.done   = done;

endmodule

// File: tb/tb_irq_seq.sv
// Directed bench for irq_seq: a cycle table of inputs and expected outputs, plus
// hand-written sequences for rdy stalls, entry latency and (with IRQ_EDGE_EN) edge channels.
module tb_irq_seq;

    logic clk = 1'b0;
    logic reset;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    irq_seq_if #(.NUM_IRQ(4)) bus ();

    irq_seq #(
        .NUM_IRQ (4),
        .VEC_BASE(8'hE0),
        .NMI_SYNC(2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        string      name;
        bit         rst, rdy, sync, i, brk, nmi;
        bit [3:0]   irq, mask;
        bit [19:0]  exp;
    } vec_t;

    vec_t tbl[$];

    // Packed output word: take busy WE do_op sp_dec vec B src done
    function automatic bit [19:0] o(bit take, bit busy, bit we, bit [1:0] dop, bit sp,
                                    bit [7:0] v, bit b, bit [3:0] s, bit dn);
        return {take, busy, we, dop, sp, v, b, s, dn};
    endfunction

    function automatic vec_t mkv(string name, bit rst, bit rdy, bit sync, bit i, bit brk,
                                 bit nmi, bit [3:0] irq, bit [3:0] mask, bit [19:0] exp);
        vec_t r;
        r.name = name; r.rst = rst; r.rdy = rdy; r.sync = sync; r.i = i; r.brk = brk;
        r.nmi = nmi; r.irq = irq; r.mask = mask; r.exp = exp;
        return r;
    endfunction

    function automatic logic [19:0] outs();
        return {bus.take, bus.busy, bus.WE, bus.do_op, bus.sp_dec, bus.vec, bus.B, bus.src,
                bus.done};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int  cyc;
        bit  got;

        reset        = 1'b1;
        bus.rdy      = 1'b1;
        bus.sync     = 1'b0;
        bus.I        = 1'b0;
        bus.brk      = 1'b0;
        bus.nmi      = 1'b0;
        bus.irq      = '0;
        bus.irq_mask = '0;
        bus.edge_sel = '0;

        // Reset sequence
        tbl.push_back(mkv("rst_hold", 0,1,0,0,0,0, 4'h0,4'h0, o(0,0,0,0,0,8'hFC,0,10,0)));
        tbl.push_back(mkv("rst0",     1,1,0,0,0,0, 4'h0,4'h0, o(0,1,0,0,1,8'hFC,0,10,0)));
        tbl.push_back(mkv("rst1",     1,1,0,0,0,0, 4'h0,4'h0, o(0,1,0,0,1,8'hFC,0,10,0)));
        tbl.push_back(mkv("rst2",     1,1,0,0,0,0, 4'h0,4'h0, o(0,1,0,0,1,8'hFC,0,10,0)));
        tbl.push_back(mkv("rst_vecl", 1,1,0,0,0,0, 4'h0,4'h0, o(0,1,0,0,0,8'hFC,0,10,0)));
        tbl.push_back(mkv("rst_vech", 1,1,0,0,0,0, 4'h0,4'h0, o(0,1,0,0,0,8'hFD,0,10,1)));
        tbl.push_back(mkv("rst_idle", 1,1,0,0,0,0, 4'h0,4'h0, o(0,0,0,0,0,8'hFC,0,10,0)));
        // NMI pulse, taken three cycles later through the synchroniser
        tbl.push_back(mkv("nmi_pulse",1,1,0,0,0,1, 4'h0,4'h0, o(0,0,0,0,0,8'hFC,0,10,0)));
        tbl.push_back(mkv("nmi_wait1",1,1,0,0,0,0, 4'h0,4'h0, o(0,0,0,0,0,8'hFC,0,10,0)));
        tbl.push_back(mkv("nmi_wait2",1,1,0,0,0,0, 4'h0,4'h0, o(0,0,0,0,0,8'hFC,0,10,0)));
        tbl.push_back(mkv("nmi_take", 1,1,1,0,0,0, 4'h0,4'h0, o(1,0,0,0,0,8'hFC,0,10,0)));
        tbl.push_back(mkv("nmi_pushh",1,1,0,0,0,0, 4'h0,4'h0, o(0,1,1,3,1,8'hFA,0,9,0)));
        tbl.push_back(mkv("nmi_pushl",1,1,0,0,0,0, 4'h0,4'h0, o(0,1,1,2,1,8'hFA,0,9,0)));
        tbl.push_back(mkv("nmi_pushp",1,1,0,0,0,0, 4'h0,4'h0, o(0,1,1,1,1,8'hFA,0,9,0)));
        tbl.push_back(mkv("nmi_vecl", 1,1,0,0,0,0, 4'h0,4'h0, o(0,1,0,0,0,8'hFA,0,9,0)));
        tbl.push_back(mkv("nmi_vech", 1,1,0,0,0,0, 4'h0,4'h0, o(0,1,0,0,0,8'hFB,0,9,1)));
        tbl.push_back(mkv("nmi_again",1,1,1,0,0,0, 4'h0,4'h0, o(0,0,0,0,0,8'hFA,0,9,0)));
        // Level channels 1 and 2: channel 1 wins; then I=1 blocks; BRK ignores I
        tbl.push_back(mkv("lvl_w0",   1,1,0,0,0,0, 4'h6,4'hF, o(0,0,0,0,0,8'hFA,0,9,0)));
        tbl.push_back(mkv("lvl_w1",   1,1,0,0,0,0, 4'h6,4'hF, o(0,0,0,0,0,8'hFA,0,9,0)));
        tbl.push_back(mkv("lvl_take", 1,1,1,0,0,0, 4'h6,4'hF, o(1,0,0,0,0,8'hFA,0,9,0)));
        tbl.push_back(mkv("lvl_pushh",1,1,0,0,0,0, 4'h6,4'hF, o(0,1,1,3,1,8'hE2,0,1,0)));
        tbl.push_back(mkv("lvl_pushl",1,1,0,0,0,0, 4'h6,4'hF, o(0,1,1,2,1,8'hE2,0,1,0)));
        tbl.push_back(mkv("lvl_pushp",1,1,0,0,0,0, 4'h6,4'hF, o(0,1,1,1,1,8'hE2,0,1,0)));
        tbl.push_back(mkv("lvl_vecl", 1,1,0,0,0,0, 4'h6,4'hF, o(0,1,0,0,0,8'hE2,0,1,0)));
        tbl.push_back(mkv("lvl_vech", 1,1,0,0,0,0, 4'h6,4'hF, o(0,1,0,0,0,8'hE3,0,1,1)));
        tbl.push_back(mkv("lvl_imask",1,1,1,1,0,0, 4'h6,4'hF, o(0,0,0,0,0,8'hE2,0,1,0)));
        tbl.push_back(mkv("brk_take", 1,1,1,1,1,0, 4'h6,4'hF, o(1,0,0,0,0,8'hE2,0,1,0)));
        tbl.push_back(mkv("brk_pushh",1,1,0,1,0,0, 4'h6,4'hF, o(0,1,1,3,1,8'hFE,1,8,0)));
        tbl.push_back(mkv("brk_pushl",1,1,0,1,0,0, 4'h6,4'hF, o(0,1,1,2,1,8'hFE,1,8,0)));
        tbl.push_back(mkv("brk_pushp",1,1,0,1,0,0, 4'h6,4'hF, o(0,1,1,1,1,8'hFE,1,8,0)));
        tbl.push_back(mkv("brk_vecl", 1,1,0,1,0,0, 4'h6,4'hF, o(0,1,0,0,0,8'hFE,1,8,0)));
        tbl.push_back(mkv("brk_vech", 1,1,0,1,0,0, 4'h6,4'hF, o(0,1,0,0,0,8'hFF,1,8,1)));
        tbl.push_back(mkv("brk_idle", 1,1,0,0,0,0, 4'h0,4'h0, o(0,0,0,0,0,8'hFE,1,8,0)));
        // NMI and level channel 0 together: NMI first; rdy=0 stalls PUSHL
        tbl.push_back(mkv("both_set", 1,1,0,0,0,1, 4'h1,4'h1, o(0,0,0,0,0,8'hFE,1,8,0)));
        tbl.push_back(mkv("both_w1",  1,1,0,0,0,0, 4'h1,4'h1, o(0,0,0,0,0,8'hFE,1,8,0)));
        tbl.push_back(mkv("both_w2",  1,1,0,0,0,0, 4'h1,4'h1, o(0,0,0,0,0,8'hFE,1,8,0)));
        tbl.push_back(mkv("both_nmi", 1,1,1,0,0,0, 4'h1,4'h1, o(1,0,0,0,0,8'hFE,1,8,0)));
        tbl.push_back(mkv("both_ph",  1,1,0,0,0,0, 4'h1,4'h1, o(0,1,1,3,1,8'hFA,0,9,0)));
        tbl.push_back(mkv("stall_pl1",1,0,0,0,0,0, 4'h1,4'h1, o(0,1,1,2,1,8'hFA,0,9,0)));
        tbl.push_back(mkv("stall_pl2",1,0,0,0,0,0, 4'h1,4'h1, o(0,1,1,2,1,8'hFA,0,9,0)));
        tbl.push_back(mkv("stall_pl3",1,1,0,0,0,0, 4'h1,4'h1, o(0,1,1,2,1,8'hFA,0,9,0)));
        tbl.push_back(mkv("both_pp",  1,1,0,0,0,0, 4'h1,4'h1, o(0,1,1,1,1,8'hFA,0,9,0)));
        tbl.push_back(mkv("both_vecl",1,1,0,0,0,1, 4'h1,4'h1, o(0,1,0,0,0,8'hFA,0,9,0)));
        tbl.push_back(mkv("both_vech",1,1,0,0,0,0, 4'h1,4'h1, o(0,1,0,0,0,8'hFB,0,9,1)));
        tbl.push_back(mkv("ch0_take", 1,1,1,0,0,0, 4'h1,4'h1, o(1,0,0,0,0,8'hFA,0,9,0)));
        tbl.push_back(mkv("ch0_pushh",1,1,0,0,0,0, 4'h1,4'h1, o(0,1,1,3,1,8'hE0,0,0,0)));
        tbl.push_back(mkv("ch0_pushl",1,0,0,0,0,0, 4'h1,4'h1, o(0,1,1,2,1,8'hE0,0,0,0)));
        // Reset mid-PUSHL with an NMI pending: immediate quiet outputs, pend lost
        tbl.push_back(mkv("abort_rst",0,1,0,0,0,0, 4'h0,4'h0, o(0,0,0,0,0,8'hFC,0,10,0)));
        tbl.push_back(mkv("ab_rst0",  1,1,0,0,0,0, 4'h0,4'h0, o(0,1,0,0,1,8'hFC,0,10,0)));
        tbl.push_back(mkv("ab_rst1",  1,1,0,0,0,0, 4'h0,4'h0, o(0,1,0,0,1,8'hFC,0,10,0)));
        tbl.push_back(mkv("ab_rst2",  1,1,0,0,0,0, 4'h0,4'h0, o(0,1,0,0,1,8'hFC,0,10,0)));
        tbl.push_back(mkv("ab_vecl",  1,1,0,0,0,0, 4'h0,4'h0, o(0,1,0,0,0,8'hFC,0,10,0)));
        tbl.push_back(mkv("ab_vech",  1,1,0,0,0,0, 4'h0,4'h0, o(0,1,0,0,0,8'hFD,0,10,1)));
        tbl.push_back(mkv("ab_nopend",1,1,1,0,0,0, 4'h0,4'h0, o(0,0,0,0,0,8'hFC,0,10,0)));

        #1;
        foreach (tbl[n]) begin
            reset        = tbl[n].rst;
            bus.rdy      = tbl[n].rdy;
            bus.sync     = tbl[n].sync;
            bus.I        = tbl[n].i;
            bus.brk      = tbl[n].brk;
            bus.nmi      = tbl[n].nmi;
            bus.irq      = tbl[n].irq;
            bus.irq_mask = tbl[n].mask;
            #1;
            check(tbl[n].name, 32'(outs()), 32'(tbl[n].exp));
            @(posedge clk);
            #1;
        end

        // rdy=0 at sync blocks the take; channel 3 then enters and reaches done in 5 cycles
        bus.sync = 1'b0; bus.irq = 4'b1000; bus.irq_mask = 4'b1000;
        tick();
        tick();
        bus.sync = 1'b1; bus.rdy = 1'b0;
        #1;
        check("rdy_low_take", 32'(bus.take), 32'd0);
        tick();
        check("rdy_low_busy", 32'(bus.busy), 32'd0);
        bus.rdy = 1'b1;
        #1;
        check("rdy_high_take", 32'(bus.take), 32'd1);
        tick();
        bus.sync = 1'b0;
        got = 1'b0;
        cyc = 0;
        for (int n = 1; n <= 10 && !got; n++) begin
            #1;
            if (bus.done) begin
                got = 1'b1;
                cyc = n;
            end else begin
                tick();
            end
        end
        check("ch3_done_latency", 32'(cyc), 32'd5);
        check("ch3_vech", {20'h0, bus.src, bus.vec}, {20'h0, 4'd3, 8'hE7});
        tick();
        bus.irq = '0; bus.irq_mask = '0;
        tick();
        tick();

`ifdef IRQ_EDGE_EN
        // Edge channel 3: pulse while masked is latched, taken after unmask, then cleared
        bus.edge_sel = 4'b1000;
        bus.irq      = 4'b1000;
        tick();
        bus.irq = '0;
        tick();
        tick();
        bus.sync = 1'b1;
        #1;
        check("edge_masked_take", 32'(bus.take), 32'd0);
        tick();
        bus.irq_mask = 4'b1000;
        #1;
        check("edge_unmask_take", 32'(bus.take), 32'd1);
        tick();
        bus.sync = 1'b0;
        check("edge_pushh", {20'h0, bus.src, bus.vec}, {20'h0, 4'd3, 8'hE6});
        for (int n = 0; n < 5; n++) tick();
        bus.sync = 1'b1;
        #1;
        check("edge_cleared_take", 32'(bus.take), 32'd0);
        tick();
        bus.sync = 1'b0;
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
